// File: rtl/msg_scroll_src.sv
// Scrolling text source for a 12-digit 14-segment display multiplexer.
// Latency: segm_out is registered, one clk after digit_idx is sampled.
// Backpressure: wr_ready is high in IDLE/LOAD, low in RUN and while in reset.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   vdd, vss                power pins (USE_POWER_PINS only)
//   clear                   sync pulse: drop the message, return to IDLE
//   wr_valid/wr_ready       character write handshake
//   wr_char, wr_last        character code (0=space, 1..26=A..Z, 27..36=0..9), end marker
//   scroll_en               enables the scroll prescaler
//   digit_idx -> segm_out   digit lookup, registered 14-segment pattern (bit13 = a)
//   msg_len, running        stored length, high in RUN
module msg_scroll_src #(
  parameter int          MSG_DEPTH  = 32,
  parameter int          DIGITS     = 12,
  parameter logic [23:0] SCROLL_DIV = 24'd6000000
) (
`ifdef USE_POWER_PINS
  inout  wire                           vdd,
  inout  wire                           vss,
`endif
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [5:0]                    wr_char,
  input  logic                          wr_last,
  input  logic                          scroll_en,
  input  logic [3:0]                    digit_idx,
  output logic [13:0]                   segm_out,
  output logic [$clog2(MSG_DEPTH):0]    msg_len,
  output logic                          running
);

  localparam int PW = $clog2(MSG_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DIG_L  = LW'(DIGITS);
  localparam logic [3:0]    DIG_4  = 4'(DIGITS);
  localparam logic [23:0]   DIV_M1 = SCROLL_DIV - 24'd1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] offset;
  logic [23:0]   prescaler;
  logic [5:0]    buffer [MSG_DEPTH];

  logic          accept;
  logic [LW-1:0] sum;
  logic [PW-1:0] rd_idx;
  logic          rd_hit;

  // wr_ready is already low in RUN, the state term only guards the handshake.
  assign accept = wr_valid && wr_ready && (state != RUN);

  // Team 14-segment font: a b c d e f g1 g2 | ul uc ur lr lc ll (bit13..bit0).
  function automatic logic [13:0] font(input logic [5:0] c);
    case (c)
      6'd1:  font = 14'b11101111000000; // A
      6'd2:  font = 14'b11110001010010; // B
      6'd3:  font = 14'b10011100000000; // C
      6'd4:  font = 14'b11110000010010; // D
      6'd5:  font = 14'b10011110000000; // E
      6'd6:  font = 14'b10001110000000; // F
      6'd7:  font = 14'b10111101000000; // G
      6'd8:  font = 14'b01101111000000; // H
      6'd9:  font = 14'b10010000010010; // I
      6'd10: font = 14'b01111000000000; // J
      6'd11: font = 14'b00001110001100; // K
      6'd12: font = 14'b00011100000000; // L
      6'd13: font = 14'b01101100101000; // M
      6'd14: font = 14'b01101100100100; // N
      6'd15: font = 14'b11111100000000; // O
      6'd16: font = 14'b11001111000000; // P
      6'd17: font = 14'b11111100000100; // Q
      6'd18: font = 14'b11001111000100; // R
      6'd19: font = 14'b10110111000000; // S
      6'd20: font = 14'b10000000010010; // T
      6'd21: font = 14'b01111100000000; // U
      6'd22: font = 14'b00001100001001; // V
      6'd23: font = 14'b01101100000101; // W
      6'd24: font = 14'b00000000101101; // X
      6'd25: font = 14'b00000000101010; // Y
      6'd26: font = 14'b10010000001001; // Z
      6'd27: font = 14'b11111100001001; // 0
      6'd28: font = 14'b01100000001000; // 1
      6'd29: font = 14'b11011011000000; // 2
      6'd30: font = 14'b11110001000000; // 3
      6'd31: font = 14'b01100111000000; // 4
      6'd32: font = 14'b10110111000000; // 5
      6'd33: font = 14'b10111111000000; // 6
      6'd34: font = 14'b11100000000000; // 7
      6'd35: font = 14'b11111111000000; // 8
      6'd36: font = 14'b11110111000000; // 9
      default: font = 14'b0;            // space and 37..63
    endcase
  endfunction

  // Window lookup. offset < msg_len and digit_idx < DIGITS < msg_len, so the
  // sum is below 2*msg_len and one conditional subtract wraps it.
  always_comb begin
    sum    = {1'b0, offset} + LW'(digit_idx);
    rd_idx = '0;
    rd_hit = 1'b0;
    if (state == RUN && digit_idx < DIG_4) begin
      if (msg_len <= DIG_L) begin
        rd_hit = LW'(digit_idx) < msg_len;
        rd_idx = PW'(digit_idx);
      end else begin
        rd_hit = 1'b1;
        rd_idx = PW'((sum >= msg_len) ? sum - msg_len : sum);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segm_out <= '0;
    end else begin
      segm_out <= rd_hit ? font(buffer[rd_idx]) : 14'b0;
    end
  end

  // Message storage, no reset; a write coinciding with clear is dropped.
  always_ff @(posedge clk) begin
    if (accept && !clear) begin
      buffer[wr_ptr] <= wr_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      msg_len   <= '0;
      offset    <= '0;
      prescaler <= '0;
      wr_ready  <= 1'b0;
      running   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      msg_len   <= '0;
      offset    <= '0;
      prescaler <= '0;
      wr_ready  <= 1'b1;
      running   <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          wr_ready <= 1'b1;
          if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
            // Filling the last entry ends the message even without wr_last.
            if (wr_last || (&wr_ptr)) begin
              state     <= RUN;
              msg_len   <= {1'b0, wr_ptr} + LW'(1);
              offset    <= '0;
              prescaler <= '0;
              wr_ready  <= 1'b0;
              running   <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        RUN: begin
          if (msg_len > DIG_L && scroll_en) begin
            if (prescaler == DIV_M1) begin
              prescaler <= '0;
              if ({1'b0, offset} + LW'(1) == msg_len) offset <= '0;
              else                                    offset <= offset + PW'(1);
            end else begin
              prescaler <= prescaler + 24'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          wr_ready <= 1'b1;
          running  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/msg_scroll_src.md
Name: msg_scroll_src

Overview:
- Upstream character source for the 12-digit 14-segment display multiplexer.
- Holds a loadable text message of up to MSG_DEPTH characters and presents a 12-character window that scrolls left at a programmable rate.
- The mux drives digit_idx with its digit counter. This block returns the registered 14-segment pattern for that digit, which the mux forwards to segm.

Parameters:
- MSG_DEPTH, 32, message buffer entries (power of 2, 16..64).
- DIGITS, 12, display positions.
- SCROLL_DIV, 24'd6000000, clk cycles per one-character scroll step (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vdd/vss  inout  1  power pins, present only under USE_POWER_PINS
- clear  in  1  synchronous pulse: discard the message and return to IDLE
- wr_valid  in  1  character write request
- wr_ready  out  1  buffer accepting characters
- wr_char  in  6  character code: 0=space, 1..26=A..Z, 27..36=digits 0..9, 37..63=blank
- wr_last  in  1  marks the final character of the message
- scroll_en  in  1  enables the scroll prescaler
- digit_idx  in  4  digit being displayed (0..11)
- segm_out  out  14  segment pattern for digit_idx
- msg_len  out  $clog2(MSG_DEPTH)+1  stored message length
- running  out  1  high in RUN state

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, wr_ptr=0, msg_len=0, offset=0, prescaler=0.
  - segm_out=0, wr_ready=0 during reset, running=0.
- FSM states IDLE, LOAD, RUN:
  - IDLE: wr_ready=1. On the first accepted write, go to LOAD, or straight to RUN if wr_last is set.
  - LOAD: wr_ready=1. Each accept stores buffer[wr_ptr]=wr_char and increments wr_ptr.
  - LOAD exits to RUN on an accept with wr_last=1, or on the accept that fills entry MSG_DEPTH-1 (implicit last). On exit, msg_len = number of accepted characters; offset and prescaler are cleared.
  - RUN: wr_ready=0. Writes are ignored.
- Accept means wr_valid && wr_ready on a rising clk. wr_char may change only after an accept.
- clear has priority over everything: in any state, next cycle is IDLE with msg_len=0, wr_ptr=0, offset=0, prescaler=0. Buffer contents are not erased.
- Scrolling, RUN only, and only when msg_len > DIGITS:
  - The prescaler counts while scroll_en=1 and holds while scroll_en=0.
  - At prescaler==SCROLL_DIV-1: prescaler goes to 0 and offset goes to (offset+1==msg_len) ? 0 : offset+1.
  - When msg_len <= DIGITS, offset stays 0 and the prescaler stays 0.
- Window mapping, registered with latency 1 (segm_out at edge N+1 reflects digit_idx sampled at edge N):
  - If state!=RUN or digit_idx>=DIGITS: segm_out=0.
  - If msg_len <= DIGITS: digit_idx < msg_len gives font(buffer[digit_idx]); otherwise 0.
  - If msg_len > DIGITS: p = offset+digit_idx; if p>=msg_len then p -= msg_len (a single subtract suffices because sum < 2*msg_len). segm_out = font(buffer[p]).
- Font: combinational ROM using the team 14-segment encoding, bit13 = segment a.
  - Required entries: A=14'b11101111000000, E=14'b10011110000000, I=14'b10010000010010, L=14'b00011100000000, O=14'b11111100000000, R=14'b11001111000100, S=14'b10110111000000.
  - Space and codes 37..63 map to 0. All other letters and digits follow the team table.
- Simultaneous events:
  - A scroll step and a digit lookup in the same cycle: the lookup uses the pre-step offset.
  - clear together with a write accept: clear wins and the write is dropped.
- Buffer is flops, no reset required for contents.

Test Plan:
- Reset mid-RUN: assert rst_n=0 asynchronously -> immediately segm_out=0, running=0, msg_len=0. After release, wr_ready=1.
- Short message: load L,O,S with wr_last on S; sweep digit_idx 0..11 -> segm_out = 14'b00011100000000, 14'b11111100000000, 14'b10110111000000, then 0 for idx 3..11. msg_len=3, offset stays 0 with scroll_en=1.
- Scroll wrap: SCROLL_DIV=4, load 13 chars "LOS RIALES AL", scroll_en=1 -> offset increments every 4 cycles, runs 0..12 then returns to 0. At offset=12, digit_idx=0 shows L and digit_idx=1 shows L (p=0).
- Implicit full: MSG_DEPTH=16, write 16 chars with no wr_last -> RUN after the 16th accept, msg_len=16, wr_ready=0. A 17th wr_valid is ignored.
- Clear with write: in LOAD, assert clear and an accepted write in the same cycle -> IDLE next cycle, msg_len=0, segm_out=0 next lookup.
- Out-of-range and hold: digit_idx=12..15 -> segm_out=0. scroll_en=0 for 100 cycles -> offset unchanged, and the prescaler resumes from its held value.
